// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and synchronous flush.
// SKID=0 is a single register with combinational ready; SKID=1 adds a skid entry so in_ready comes from a flop.
module pipe_stage_skid #(
  parameter int DATA_W    = 256,
  parameter int SKID      = 1,
  parameter int FLUSH_CLR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  generate
    if (SKID == 0) begin : g_single
      logic              valid_reg;
      logic [DATA_W-1:0] main_reg;
      logic              push;
      logic              pop;

      assign in_ready  = ~valid_reg | out_ready;
      assign push      = in_valid & in_ready & ~flush;
      assign pop       = valid_reg & out_ready;
      assign out_valid = valid_reg;
      assign out_data  = main_reg;
      assign occ       = {1'b0, valid_reg};

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          main_reg  <= '0;
        end else if (flush) begin
          valid_reg <= 1'b0;
          if (FLUSH_CLR != 0) main_reg <= '0;
        end else if (push) begin
          valid_reg <= 1'b1;
          main_reg  <= in_data;
        end else if (pop) begin
          valid_reg <= 1'b0;
        end
      end
    end else begin : g_skid
      state_t            state_reg, state_next;
      logic [DATA_W-1:0] main_reg, main_next;
      logic [DATA_W-1:0] skid_reg, skid_next;
      logic              in_ready_reg;
      logic              push;
      logic              pop;

      assign push      = in_valid & in_ready_reg & ~flush;
      assign pop       = (state_reg != EMPTY) & out_ready;
      assign in_ready  = in_ready_reg;
      assign out_valid = (state_reg != EMPTY);
      assign out_data  = main_reg;
      assign occ       = state_reg;

      always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
          state_next = EMPTY;
          if (FLUSH_CLR != 0) begin
            main_next = '0;
            skid_next = '0;
          end
        end else begin
          case (state_reg)
            EMPTY: begin
              if (push) begin
                state_next = ONE;
                main_next  = in_data;
              end
            end
            ONE: begin
              if (push && pop) begin
                main_next = in_data;
              end else if (push) begin
                state_next = FULL;
                skid_next  = in_data;
              end else if (pop) begin
                state_next = EMPTY;
              end
            end
            FULL: begin
              // in_ready is low here, so only a pop can move the state.
              if (pop) begin
                state_next = ONE;
                main_next  = skid_reg;
              end
            end
            default: state_next = EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg    <= EMPTY;
          main_reg     <= '0;
          skid_reg     <= '0;
          in_ready_reg <= 1'b1;
        end else begin
          state_reg    <= state_next;
          main_reg     <= main_next;
          skid_reg     <= skid_next;
          in_ready_reg <= (state_next != FULL);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives a skid (SKID=1) and a single-register (SKID=0) instance with shared stimulus
// and checks both against queue-based reference models.
module tb_pipe_stage_skid;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_data1, out_data0;
  logic [1:0]    occ1, occ0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference models: ordered queues of held beats, capacity 2 and 1.
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];
  bit z1, z0;       // storage known to read zero (after reset/flush, before any push)
  bit known = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .FLUSH_CLR(1)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occ(occ1)
  );

  pipe_stage_skid #(.DATA_W(DW), .SKID(0), .FLUSH_CLR(1)) u_single (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occ(occ0)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Check both DUTs against the models mid-cycle, then advance one edge and update the models.
  task automatic tick();
    bit r1, r0, push1, push0, pop1, pop0;
    @(negedge clk);
    r1 = (q1.size() < 2);
    r0 = (q0.size() == 0) || out_ready;
    if (known) begin
      chk("s1_valid", 64'(out_valid1), 64'(q1.size() > 0));
      chk("s1_occ",   64'(occ1),       64'(q1.size()));
      chk("s1_ready", 64'(in_ready1),  64'(r1));
      if (q1.size() > 0) chk("s1_data", out_data1, q1[0]);
      else if (z1)       chk("s1_zero", out_data1, '0);
      chk("s0_valid", 64'(out_valid0), 64'(q0.size() > 0));
      chk("s0_occ",   64'(occ0),       64'(q0.size()));
      chk("s0_ready", 64'(in_ready0),  64'(r0));
      if (q0.size() > 0) chk("s0_data", out_data0, q0[0]);
      else if (z0)       chk("s0_zero", out_data0, '0);
    end
    push1 = in_valid && r1 && !flush;
    push0 = in_valid && r0 && !flush;
    pop1  = (q1.size() > 0) && out_ready;
    pop0  = (q0.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (!rst_n || flush) begin
      q1.delete();
      q0.delete();
      z1 = 1;
      z0 = 1;
      if (!rst_n) known = 1;
    end else begin
      if (pop1) q1.delete(0);
      if (push1) begin q1.push_back(in_data); z1 = 0; end
      if (pop0) q0.delete(0);
      if (push0) begin q0.push_back(in_data); z0 = 0; end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid1), 64'd0);
    chk("rst_occ",   64'(occ1),       64'd0);
    chk("rst_data",  out_data1,       64'd0);
    chk("rst_ready", 64'(in_ready1),  64'd1);

    // Streaming with out_ready held high.
    drive(1'b1, 64'h11, 1'b1, 1'b0); tick();
    chk("stream_0x11", out_data1, 64'h11);
    drive(1'b1, 64'h22, 1'b1, 1'b0); tick();
    chk("stream_0x22", out_data1, 64'h22);
    chk("stream_occ",  64'(occ1), 64'd1);
    drive(1'b1, 64'h33, 1'b1, 1'b0); tick();
    chk("stream_0x33", out_data1, 64'h33);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    chk("stream_drain", 64'(out_valid1), 64'd0);

    // Backpressure fills the skid entry.
    drive(1'b1, 64'hA1, 1'b0, 1'b0); tick();
    drive(1'b1, 64'hA2, 1'b0, 1'b0); tick();
    chk("bp_occ",   64'(occ1),      64'd2);
    chk("bp_ready", 64'(in_ready1), 64'd0);
    chk("bp_hold",  out_data1,      64'hA1);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    chk("bp_second", out_data1,      64'hA2);
    chk("bp_ready1", 64'(in_ready1), 64'd1);
    tick();
    chk("bp_empty", 64'(out_valid1), 64'd0);

    // Flush while FULL discards the incoming beat and clears storage.
    drive(1'b1, 64'hB1, 1'b0, 1'b0); tick();
    drive(1'b1, 64'hB2, 1'b0, 1'b0); tick();
    chk("fl_full", 64'(occ1), 64'd2);
    drive(1'b1, 64'hBB, 1'b0, 1'b1); tick();
    chk("fl_valid", 64'(out_valid1), 64'd0);
    chk("fl_occ",   64'(occ1),       64'd0);
    chk("fl_data",  out_data1,       64'd0);
    drive(1'b0, '0, 1'b1, 1'b1); tick();
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    chk("fl_no_bb", 64'(out_valid1), 64'd0);

    // Single-register stall behaviour.
    drive(1'b1, 64'h5, 1'b0, 1'b0); tick();
    chk("s0_load", out_data0, 64'h5);
    drive(1'b1, 64'h6, 1'b0, 1'b0);
    #1;
    chk("s0_stall_ready", 64'(in_ready0), 64'd0);
    tick();
    chk("s0_stall_hold", out_data0, 64'h5);
    drive(1'b1, 64'h6, 1'b1, 1'b0); tick();
    chk("s0_next", out_data0, 64'h6);
    drive(1'b0, '0, 1'b1, 1'b0); tick();

    // Randomised traffic against the reference models.
    for (int i = 0; i < 10000; i++) begin
      rst_n = ($urandom_range(0, 999) != 0);
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3));
      tick();
    end
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
